uop_replay_sequencer: RTL
=========================

// Module: uop_replay_sequencer
// PURPOSE
//  Sequences the single-port uop cache RAM for the loop buffer: captures one loop body from the fill
//  stream, then replays it to the fetch mux as an endless wrap-around instruction stream until stopped.
//  Sits between the loop-detect FSM (fill/start/stop) and the uop cache RAM; owns every RAM access.
//  Fill and replay share the one RAM port and are mutually exclusive by state.
// PARAMETERS
//  DATA_W  32  instruction width
//  DEPTH   8   RAM entries (max loop body length, instructions)
//  ADDR_W  3   log2(DEPTH)
// PORTS
//  clk          in   1       clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  fill_valid   in   1       fill beat offered
//  fill_ready   out  1       fill beat accepted when valid&ready
//  fill_data    in   DATA_W  instruction to store
//  fill_last    in   1       beat is the last instruction of the loop body
//  replay_start in   1       pulse: begin replay of the stored loop
//  replay_stop  in   1       pulse: mispredict/flush, abort replay, keep loop
//  invalidate   in   1       pulse: discard stored loop, abort everything
//  rep_valid    out  1       replay instruction available
//  rep_ready    in   1       consumer takes rep_data when valid&ready
//  rep_data     out  DATA_W  replayed instruction
//  rep_index    out  ADDR_W  loop index of rep_data
//  loop_valid   out  1       a complete loop body is stored
//  loop_len     out  ADDR_W+1  stored body length, 1..DEPTH
//  overflow     out  1       1-cycle pulse: fill exceeded DEPTH
//  ram_en/ram_we out 1 each  RAM enable / write enable
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after ram_en&!ram_we
// BEHAVIOUR
//  Reset: state=IDLE; wr_ptr, rd_ptr, FIFO, loop_len, loop_valid, overflow, rep_valid=0. Mid-op reset aborts at once.
//  States: IDLE (empty), FILL (capturing), LOADED (loop held), REPLAY (streaming).
//  fill_ready=1 in IDLE, FILL, LOADED; 0 in REPLAY. ram_*: combinational from state/handshakes.
//  Fill beat: ram_en=ram_we=1, ram_addr=wr_ptr, ram_wdata=fill_data; wr_ptr++.
//   First beat in IDLE/LOADED: loop_valid<=0, wr_ptr from 0, ->FILL (or stays LOADED if also last).
//   Beat with fill_last: loop_len<=wr_ptr+1, loop_valid<=1, wr_ptr<=0, ->LOADED.
//   Beat at wr_ptr==DEPTH-1 without last: overflow pulse next cycle, loop_valid<=0, ->IDLE.
//  replay_start honoured only in LOADED (ignored elsewhere): ->REPLAY, rd_ptr=0.
//  REPLAY: 2-entry output FIFO; issue read (ram_en=1, ram_we=0, ram_addr=rd_ptr) when
//   FIFO occupancy + reads in flight - (pop this cycle) < 2. rd_ptr wraps loop_len-1 -> 0.
//   Returned data + index pushed next cycle; rep_valid = FIFO non-empty; stable while !rep_ready.
//   Latency: start at cycle t -> first read t+1 -> rep_valid with index 0 at t+2; 1 beat/cycle sustained.
//  replay_stop in REPLAY: FIFO cleared, in-flight read discarded, rep_valid=0 next cycle, ->LOADED.
//  invalidate in any state: FIFO cleared, loop_valid<=0, wr_ptr/rd_ptr<=0, ->IDLE.
//  Same-cycle priority: invalidate > replay_stop > replay_start > fill beat.
//   invalidate with a fill beat: beat not accepted (fill_ready=0 that cycle).
//  fill_valid during REPLAY is stalled, never dropped. loop_len=1 replays entry 0 every cycle.
// TESTING
//  Fill A,B,C (last on C) -> loop_valid=1, loop_len=3; start -> A,B,C,A,B,C... one per cycle from t+2, idx 0,1,2,0.
//  Replay with rep_ready toggling 1,0,0,1 -> no beat lost or duplicated; rep_data held while not ready.
//  DEPTH=8, 9 fill beats no last -> overflow pulse after 8th, loop_valid=0, state IDLE, 9th beat starts new fill.
//  replay_stop during stream after B -> rep_valid=0 next cycle; restart -> stream begins at A, idx 0.
//  Single-beat loop X (last on first beat) -> replay X,X,X; invalidate same cycle as start -> IDLE, no rep_valid.
//  reset_n low mid-replay with read in flight -> all outputs 0 immediately; after release loop_valid=0, fill_ready=1.

Source files
------------

// File: rtl/uop_replay_sequencer.sv
// Loop-buffer sequencer: captures one loop body into the single-port uop cache RAM,
// then replays it as a wrap-around stream through a 2-entry output FIFO with a read bypass.
module uop_replay_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_last,
    input  logic              replay_start,
    input  logic              replay_stop,
    input  logic              invalidate,
    output logic              rep_valid,
    input  logic              rep_ready,
    output logic [DATA_W-1:0] rep_data,
    output logic [ADDR_W-1:0] rep_index,
    output logic              loop_valid,
    output logic [ADDR_W:0]   loop_len,
    output logic              overflow,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_LOADED = 2'd2,
        S_REPLAY = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     loop_len_q, loop_len_d;
    logic                loop_valid_q, loop_valid_d;
    logic                overflow_q, overflow_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_idx_q, inflight_idx_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [DATA_W-1:0]   fifo_data_d [2];
    logic [ADDR_W-1:0]   fifo_idx_q [2];
    logic [ADDR_W-1:0]   fifo_idx_d [2];

    logic                fill_fire;
    logic [ADDR_W-1:0]   fill_addr;
    logic                fill_is_last;
    logic                fill_ovf;
    logic                start_ok;
    logic                stop_ok;
    logic                pop;
    logic                rd_issue;
    logic [2:0]          occupancy;
    logic                rd_wrap;
    logic                wr_slot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (invalidate) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FILL: begin
                    if (fill_is_last) begin
                        state_d = S_LOADED;
                    end else if (fill_ovf) begin
                        state_d = S_IDLE;
                    end else if (fill_fire) begin
                        state_d = S_FILL;
                    end
                end
                S_LOADED: begin
                    if (start_ok) begin
                        state_d = S_REPLAY;
                    end else if (fill_is_last) begin
                        state_d = S_LOADED;
                    end else if (fill_ovf) begin
                        state_d = S_IDLE;
                    end else if (fill_fire) begin
                        state_d = S_FILL;
                    end
                end
                S_REPLAY: begin
                    if (stop_ok) begin
                        state_d = S_LOADED;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A fill beat loses to invalidate and, in LOADED, to a same-cycle replay_start.
    always_comb begin
        fill_ready = !invalidate &&
                     ((state_q == S_IDLE) || (state_q == S_FILL) ||
                      ((state_q == S_LOADED) && !replay_start));
        fill_fire    = fill_valid && fill_ready;
        fill_addr    = (state_q == S_FILL) ? wr_ptr_q : '0;
        fill_is_last = fill_fire && fill_last;
        fill_ovf     = fill_fire && !fill_last && (fill_addr == ADDR_W'(DEPTH - 1));
        start_ok     = replay_start && !invalidate && (state_q == S_LOADED);
        stop_ok      = replay_stop && !invalidate && (state_q == S_REPLAY);

        rep_valid = (fifo_cnt_q != 2'd0) || inflight_q;
        rep_data  = '0;
        rep_index = '0;
        if (fifo_cnt_q != 2'd0) begin
            rep_data  = fifo_data_q[0];
            rep_index = fifo_idx_q[0];
        end else if (inflight_q) begin
            rep_data  = ram_rdata;
            rep_index = inflight_idx_q;
        end
        pop = rep_valid && rep_ready;

        occupancy = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
        rd_issue  = (state_q == S_REPLAY) && !invalidate && !replay_stop && (occupancy < 3'd2);

        ram_en    = fill_fire || rd_issue;
        ram_we    = fill_fire;
        ram_addr  = fill_fire ? fill_addr : rd_ptr_q;
        ram_wdata = fill_data;

        loop_valid = loop_valid_q;
        loop_len   = loop_len_q;
        overflow   = overflow_q;
    end

    // Datapath: capture bookkeeping plus the replay read pipeline and FIFO.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        loop_len_d     = loop_len_q;
        loop_valid_d   = loop_valid_q;
        overflow_d     = fill_ovf;
        inflight_d     = inflight_q;
        inflight_idx_d = inflight_idx_q;
        fifo_cnt_d     = fifo_cnt_q;
        fifo_data_d    = fifo_data_q;
        fifo_idx_d     = fifo_idx_q;
        rd_wrap        = ({1'b0, rd_ptr_q} == (loop_len_q - (ADDR_W+1)'(1)));
        wr_slot        = fifo_cnt_q[0] ^ pop;

        if (invalidate) begin
            loop_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            inflight_d   = 1'b0;
            fifo_cnt_d   = 2'd0;
        end else begin
            if (fill_is_last) begin
                loop_len_d   = {1'b0, fill_addr} + (ADDR_W+1)'(1);
                loop_valid_d = 1'b1;
                wr_ptr_d     = '0;
            end else if (fill_ovf) begin
                loop_valid_d = 1'b0;
                wr_ptr_d     = '0;
            end else if (fill_fire) begin
                loop_valid_d = 1'b0;
                wr_ptr_d     = fill_addr + ADDR_W'(1);
            end

            if (start_ok || stop_ok) begin
                rd_ptr_d   = '0;
                inflight_d = 1'b0;
                fifo_cnt_d = 2'd0;
            end else if (state_q == S_REPLAY) begin
                inflight_d     = rd_issue;
                inflight_idx_d = rd_ptr_q;
                if (rd_issue) begin
                    rd_ptr_d = rd_wrap ? '0 : rd_ptr_q + ADDR_W'(1);
                end
                fifo_cnt_d = fifo_cnt_q + 2'(inflight_q) - 2'(pop);
                if (pop && (fifo_cnt_q != 2'd0)) begin
                    fifo_data_d[0] = fifo_data_q[1];
                    fifo_idx_d[0]  = fifo_idx_q[1];
                end
                // Returning data consumed straight from the bypass is never stored.
                if (inflight_q && !(pop && (fifo_cnt_q == 2'd0))) begin
                    fifo_data_d[wr_slot] = ram_rdata;
                    fifo_idx_d[wr_slot]  = inflight_idx_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            loop_len_q     <= '0;
            loop_valid_q   <= 1'b0;
            overflow_q     <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            fifo_cnt_q     <= 2'd0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_idx_q[0]  <= '0;
            fifo_idx_q[1]  <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            loop_len_q     <= loop_len_d;
            loop_valid_q   <= loop_valid_d;
            overflow_q     <= overflow_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            fifo_cnt_q     <= fifo_cnt_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_idx_q[0]  <= fifo_idx_d[0];
            fifo_idx_q[1]  <= fifo_idx_d[1];
        end
    end

endmodule
